// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared state encoding and constants for the ALU operation scheduler
package alu_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam logic [2:0] OP_NOP = 3'h0;
  localparam int ALU_SEL_W = 3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = IW'((int'(last) + k) % N);
    any = |req;
    pick = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin sharing of one fixed-latency ALU among N requesters
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int ALU_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [3*N-1:0]       op_in,
  input  logic [W*N-1:0]       a_in,
  input  logic [W*N-1:0]       b_in,
  output logic [N-1:0]         gnt,
  output logic [ALU_SEL_W-1:0] alu_address,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  input  logic [W-1:0]         alu_result,
  output logic [W-1:0]         result,
  output logic [N-1:0]         done,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(ALU_LAT + 1);
  state_t state;
  logic [IW-1:0] last, idx, pick_idx;
  logic [N-1:0] pick;
  logic any;
  logic [CW-1:0] cnt;
  rr_arbiter #(.N(N)) u_arb (
    .req (req),
    .last(last),
    .pick(pick),
    .idx (pick_idx),
    .any (any)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      alu_address <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      result      <= '0;
      busy        <= 1'b0;
      last        <= IW'(N - 1);
      idx         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state       <= ISSUE;
          busy        <= 1'b1;
          gnt         <= pick;
          idx         <= pick_idx;
          alu_address <= op_in[3*int'(pick_idx) +: 3];
          alu_a       <= a_in[W*int'(pick_idx) +: W];
          alu_b       <= b_in[W*int'(pick_idx) +: W];
        end
        ISSUE: begin
          gnt <= '0;
          cnt <= CW'(ALU_LAT);
          if (alu_address == OP_NOP) begin
            state  <= DONE;
            result <= '0;
            done   <= N'(1) << idx;
          end else state <= WAIT;
        end
        WAIT: if (cnt == CW'(1)) begin
          state       <= DONE;
          result      <= alu_result;
          done        <= N'(1) << idx;
          alu_address <= '0;
        end else cnt <= cnt - CW'(1);
        DONE: begin
          state <= IDLE;
          done  <= '0;
          busy  <= 1'b0;
          last  <= idx;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: directed and randomized checks of the ALU operation scheduler
module tb_alu_op_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LAT = 2;
  logic clk, reset;
  logic [N-1:0] req, gnt, done;
  logic [3*N-1:0] op_in;
  logic [W*N-1:0] a_in, b_in;
  logic [2:0] alu_address;
  logic [W-1:0] alu_a, alu_b, alu_result, result, s1;
  logic busy;
  logic [2:0] r_op[N];
  logic [W-1:0] r_a[N], r_b[N];
  int checks = 0, failures = 0;
  bit m_active;
  int m_g, m_d, m_win, m_last;
  logic [2:0] m_op;
  logic [W-1:0] m_a, m_b, m_res, m_hold;

  alu_op_scheduler #(.N(N), .W(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .alu_address(alu_address), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .result(result), .done(done), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    op_in = '0; a_in = '0; b_in = '0;
    for (int i = 0; i < N; i++) begin
      op_in[3*i +: 3] = r_op[i];
      a_in[W*i +: W] = r_a[i];
      b_in[W*i +: W] = r_b[i];
    end
  end

  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      3'd7: return {a[3:0], b[3:0]};
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    s1 <= alu_f(alu_address, alu_a, alu_b);
    alu_result <= s1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; req = '0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1; req = 4'hF;
    for (int i = 0; i < N; i++) begin r_op[i] = 3'(i + 1); r_a[i] = 8'h11; r_b[i] = 8'h22; end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (gnt !== 4'h0) begin failures++; $display("FAIL reset_gnt k=%0d got=%b exp=0000", k, gnt); end
      checks++; if (done !== 4'h0) begin failures++; $display("FAIL reset_done k=%0d got=%b exp=0000", k, done); end
      checks++; if (alu_address !== 3'd0) begin failures++; $display("FAIL reset_addr k=%0d got=%0d exp=0", k, alu_address); end
      checks++; if (result !== 8'd0) begin failures++; $display("FAIL reset_result k=%0d got=%h exp=00", k, result); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, busy); end
    end
    reset = 0; req = '0;
  endtask

  task automatic test_single_op;
    logic [3:0] eg, ed;
    logic [2:0] ea;
    do_reset();
    req = 4'b0100; r_op[2] = 3'd1; r_a[2] = 8'd5; r_b[2] = 8'd7;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) req = '0;
      eg = (k == 1) ? 4'b0100 : 4'b0000;
      ed = (k == 4) ? 4'b0100 : 4'b0000;
      ea = (k <= 3) ? 3'd1 : 3'd0;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL single_gnt k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL single_done k=%0d got=%b exp=%b", k, done, ed); end
      checks++; if (alu_address !== ea) begin failures++; $display("FAIL single_addr k=%0d got=%0d exp=%0d", k, alu_address, ea); end
      checks++; if (busy !== (k <= 4)) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, k <= 4); end
      if (k <= 3) begin
        checks++; if (alu_a !== 8'd5 || alu_b !== 8'd7) begin failures++; $display("FAIL single_operands k=%0d got=%0d,%0d exp=5,7", k, alu_a, alu_b); end
      end
      if (k >= 4) begin
        checks++; if (result !== 8'd12) begin failures++; $display("FAIL single_result k=%0d got=%0d exp=12", k, result); end
      end
    end
  endtask

  task automatic test_nop;
    logic [3:0] eg, ed;
    req = 4'b1000; r_op[3] = 3'd0; r_a[3] = 8'hFF; r_b[3] = 8'($urandom);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) req = '0;
      eg = (k == 1) ? 4'b1000 : 4'b0000;
      ed = (k == 2) ? 4'b1000 : 4'b0000;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL nop_gnt k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL nop_done k=%0d got=%b exp=%b", k, done, ed); end
      checks++; if (alu_address !== 3'd0) begin failures++; $display("FAIL nop_addr k=%0d got=%0d exp=0", k, alu_address); end
      checks++; if (busy !== (k <= 2)) begin failures++; $display("FAIL nop_busy k=%0d got=%b exp=%b", k, busy, k <= 2); end
      if (k >= 2) begin
        checks++; if (result !== 8'd0) begin failures++; $display("FAIL nop_result k=%0d got=%h exp=00", k, result); end
      end
    end
  endtask

  task automatic test_rotation(input bit two_only);
    logic [3:0] eg, ed;
    int gi, di;
    do_reset();
    for (int i = 0; i < N; i++) begin r_op[i] = 3'd1; r_a[i] = 8'(16 * i + 1); r_b[i] = 8'(i + 2); end
    req = two_only ? 4'b0011 : 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      gi = two_only ? ((k - 1) / 5) % 2 : (k - 1) / 5;
      di = two_only ? ((k - 4) / 5) % 2 : (k - 4) / 5;
      eg = ((k - 1) % 5 == 0) ? 4'(1 << gi) : 4'd0;
      ed = (k >= 4 && (k - 4) % 5 == 0) ? 4'(1 << di) : 4'd0;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rot%0d_gnt k=%0d got=%b exp=%b", two_only, k, gnt, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL rot%0d_done k=%0d got=%b exp=%b", two_only, k, done, ed); end
      if (ed != 0) begin
        checks++; if (result !== 8'(r_a[di] + r_b[di])) begin failures++; $display("FAIL rot%0d_result k=%0d got=%h exp=%h", two_only, k, result, 8'(r_a[di] + r_b[di])); end
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_wait;
    logic [3:0] eg, ed;
    do_reset();
    req = 4'b0010; r_op[1] = 3'd1; r_a[1] = 8'd3; r_b[1] = 8'd4;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rmw_gnt got=%b exp=0010", gnt); end
    tick();
    checks++; if (alu_address !== 3'd1 || busy !== 1'b1) begin failures++; $display("FAIL rmw_wait got=addr%0d busy%b exp=addr1 busy1", alu_address, busy); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (done !== 4'b0 || alu_address !== 3'd0 || gnt !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rmw_after_reset got=done%b addr%0d gnt%b busy%b exp=all 0", done, alu_address, gnt, busy);
    end
    for (int k = 4; k <= 7; k++) begin
      tick();
      if (k == 4) req = '0;
      eg = (k == 4) ? 4'b0010 : 4'b0000;
      ed = (k == 7) ? 4'b0010 : 4'b0000;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rmw_regnt k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL rmw_done k=%0d got=%b exp=%b", k, done, ed); end
    end
    checks++; if (result !== 8'd7) begin failures++; $display("FAIL rmw_result got=%0d exp=7", result); end
  endtask

  task automatic test_random;
    logic [3:0] eg, ed;
    logic [2:0] ea;
    int j;
    do_reset();
    m_active = 0; m_last = N - 1; m_hold = '0;
    for (int c = 0; c < 3000; c++) begin
      eg = (m_active && c == m_g) ? 4'(1 << m_win) : 4'd0;
      ed = (m_active && c == m_d) ? 4'(1 << m_win) : 4'd0;
      if (m_active && c == m_d) m_hold = m_res;
      ea = (m_active && c >= m_g && c < m_d) ? m_op : 3'd0;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL rand_done c=%0d got=%b exp=%b", c, done, ed); end
      checks++; if (alu_address !== ea) begin failures++; $display("FAIL rand_addr c=%0d got=%0d exp=%0d", c, alu_address, ea); end
      checks++; if (result !== m_hold) begin failures++; $display("FAIL rand_result c=%0d got=%h exp=%h", c, result, m_hold); end
      checks++; if (busy !== (m_active && c >= m_g)) begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_active && c >= m_g); end
      if (m_active && c >= m_g) begin
        checks++; if (alu_a !== m_a || alu_b !== m_b) begin failures++; $display("FAIL rand_operands c=%0d got=%h,%h exp=%h,%h", c, alu_a, alu_b, m_a, m_b); end
      end
      for (int i = 0; i < N; i++) begin
        if (m_active && m_win == i) begin
          req[i] = $urandom_range(0, 1) == 1;
          r_op[i] = 3'($urandom); r_a[i] = 8'($urandom); r_b[i] = 8'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          r_op[i] = 3'($urandom); r_a[i] = 8'($urandom); r_b[i] = 8'($urandom);
        end
      end
      if (m_active && c == m_d) begin
        m_active = 0; m_last = m_win;
      end else if (!m_active && req != 0) begin
        j = -1;
        for (int k = 1; k <= N && j < 0; k++)
          if (req[(m_last + k) % N]) j = (m_last + k) % N;
        m_active = 1; m_win = j; m_g = c + 1;
        m_op = r_op[j]; m_a = r_a[j]; m_b = r_b[j];
        m_d = (m_op == 3'd0) ? c + 2 : c + 2 + LAT;
        m_res = alu_f(m_op, m_a, m_b);
      end
      tick();
    end
    req = '0;
  endtask

  initial begin
    reset = 1; req = '0;
    for (int i = 0; i < N; i++) begin r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; end
    test_reset();
    test_single_op();
    test_nop();
    test_rotation(1'b0);
    test_rotation(1'b1);
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
